// File: rtl/uart_instr_assembler_pkg.sv
// Shared definitions for the UART instruction assembler and its neighbours.
// Holds the default word geometry, the program-memory depth and the
// one-hot state encoding of the assembler FSM.
package uart_instr_assembler_pkg;

  // Defaults shared with the program-loading controller and program memory
  localparam int unsigned WORD_BYTES_DEF = 4;
  localparam int unsigned MAX_INSTR_DEF  = 32;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned COUNT_W = 6;
  localparam int unsigned STATE_W = 4;

  // One-hot state encodings
  localparam logic [STATE_W-1:0] ST_IDLE_OH    = 4'b0001;
  localparam logic [STATE_W-1:0] ST_COLLECT_OH = 4'b0010;
  localparam logic [STATE_W-1:0] ST_EMIT_OH    = 4'b0100;
  localparam logic [STATE_W-1:0] ST_DONE_OH    = 4'b1000;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = ST_IDLE_OH,
    S_COLLECT = ST_COLLECT_OH,
    S_EMIT    = ST_EMIT_OH,
    S_DONE    = ST_DONE_OH
  } state_t;

endpackage

// File: rtl/uart_instr_assembler.sv
// Pops bytes from the UART RX FIFO, parses a header byte N (instruction
// count), then packs the next N*WORD_BYTES bytes into 32-bit instruction
// words written to the instruction FIFO with a one-cycle strobe.
//
// Ports:
//   CLK, RESET     clock (rising edge), asynchronous active-high reset
//   I_RX_EMPTY     UART RX FIFO empty; I_RX_DATA valid while low
//   I_RX_DATA      head byte of the UART RX FIFO
//   O_RD_UART      pop strobe to the RX FIFO (combinational)
//   I_FIFO_FULL    instruction FIFO full
//   O_INSTRUCTION  assembled instruction word
//   O_FLAG_I       instruction FIFO write strobe (combinational)
//   O_LOADING      high while collecting/emitting words of a load
//   O_DONE         one-cycle pulse after the N-th word is written
//   O_ERR          one-cycle pulse after an illegal header byte
//   O_INSTR_COUNT  words written in the current load
module uart_instr_assembler
  import uart_instr_assembler_pkg::*;
#(
  parameter int unsigned WORD_BYTES = WORD_BYTES_DEF,
  parameter int unsigned MAX_INSTR  = MAX_INSTR_DEF,
  parameter int unsigned BIG_ENDIAN = 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                I_RX_EMPTY,
  input  logic [BYTE_W-1:0]   I_RX_DATA,
  output logic                O_RD_UART,
  input  logic                I_FIFO_FULL,
  output logic [INSTR_W-1:0]  O_INSTRUCTION,
  output logic                O_FLAG_I,
  output logic                O_LOADING,
  output logic                O_DONE,
  output logic                O_ERR,
  output logic [COUNT_W-1:0]  O_INSTR_COUNT
);

  localparam int unsigned BCNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(WORD_BYTES - 1);
  localparam logic [BYTE_W-1:0] MAX_HDR   = BYTE_W'(MAX_INSTR);

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   word_q,  word_d;
  logic [BCNT_W-1:0]    bcnt_q,  bcnt_d;
  logic [COUNT_W-1:0]   n_q,     n_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 err_q,   err_d;
  logic [INSTR_W-1:0]   shifted;
  logic                 hdr_ok;

  // Pop and write strobes are combinational so the byte/word moves on the same edge
  assign O_RD_UART = ((state_q == S_IDLE) || (state_q == S_COLLECT)) && !I_RX_EMPTY;
  assign O_FLAG_I  = (state_q == S_EMIT) && !I_FIFO_FULL;

  assign O_LOADING     = (state_q == S_COLLECT) || (state_q == S_EMIT);
  assign O_DONE        = (state_q == S_DONE);
  assign O_ERR         = err_q;
  assign O_INSTRUCTION = word_q;
  assign O_INSTR_COUNT = count_q;

  // Byte placement: big-endian shifts in at the bottom, little-endian at the top
  assign shifted = (BIG_ENDIAN != 0) ? {word_q[INSTR_W-BYTE_W-1:0], I_RX_DATA}
                                     : {I_RX_DATA, word_q[INSTR_W-1:BYTE_W]};

  // Range check on the full byte before it is narrowed into N
  assign hdr_ok = (I_RX_DATA != '0) && (I_RX_DATA <= MAX_HDR);

  // State and datapath registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      bcnt_q  <= '0;
      n_q     <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      n_q     <= n_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    n_d     = n_q;
    count_d = count_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (O_RD_UART) begin
          if (hdr_ok) begin
            n_d     = COUNT_W'(I_RX_DATA);
            count_d = '0;
            bcnt_d  = '0;
            state_d = S_COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_COLLECT: begin
        if (O_RD_UART) begin
          word_d = shifted;
          if (bcnt_q == LAST_BYTE) begin
            bcnt_d  = '0;
            state_d = S_EMIT;
          end else begin
            bcnt_d = BCNT_W'(bcnt_q + 1'b1);
          end
        end
      end

      // Word is held stable until the instruction FIFO accepts it
      S_EMIT: begin
        if (O_FLAG_I) begin
          count_d = COUNT_W'(count_q + 1'b1);
          state_d = (count_d == n_q) ? S_DONE : S_COLLECT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_instr_assembler.sv
// Scoreboard bench for uart_instr_assembler: stimulus pushes expected words
// and done counts; a negedge monitor pops and compares on every strobe.
module tb_uart_instr_assembler;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        I_RX_EMPTY;
  logic [7:0]  I_RX_DATA;
  logic        O_RD_UART;
  logic        I_FIFO_FULL;
  logic [31:0] O_INSTRUCTION;
  logic        O_FLAG_I;
  logic        O_LOADING;
  logic        O_DONE;
  logic        O_ERR;
  logic [5:0]  O_INSTR_COUNT;

  uart_instr_assembler dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .I_RX_EMPTY    (I_RX_EMPTY),
    .I_RX_DATA     (I_RX_DATA),
    .O_RD_UART     (O_RD_UART),
    .I_FIFO_FULL   (I_FIFO_FULL),
    .O_INSTRUCTION (O_INSTRUCTION),
    .O_FLAG_I      (O_FLAG_I),
    .O_LOADING     (O_LOADING),
    .O_DONE        (O_DONE),
    .O_ERR         (O_ERR),
    .O_INSTR_COUNT (O_INSTR_COUNT)
  );

  always #5 CLK = ~CLK;

  logic [31:0] exp_words[$];
  int          exp_done[$];

  int checks = 0;
  int errors = 0;
  int flag_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int pop_cnt = 0;
  int bytes_sent = 0;
  int cyc = 0;
  int last_flag_cyc = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every write strobe and done pulse against the scoreboard
  always @(negedge CLK) begin
    cyc++;
    if (RESET !== 1'b1) begin
      if (O_RD_UART === 1'b1) pop_cnt++;
      if (O_FLAG_I === 1'b1) begin
        flag_cnt++;
        check("flag_expected", 32'(exp_words.size() != 0), 32'd1);
        if (exp_words.size() != 0) check("word", O_INSTRUCTION, exp_words.pop_front());
        last_flag_cyc = cyc;
      end
      if (O_DONE === 1'b1) begin
        done_cnt++;
        check("done_expected", 32'(exp_done.size() != 0), 32'd1);
        if (exp_done.size() != 0) check("done_count", 32'(O_INSTR_COUNT), 32'(exp_done.pop_front()));
        check("done_latency", 32'(cyc - last_flag_cyc), 32'd1);
      end
      if (O_ERR === 1'b1) err_cnt++;
    end
  end

  // Offer one byte after 'gap' empty cycles; returns just after the popping edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(posedge CLK);
    if (gap > 0) #1;
    I_RX_EMPTY = 1'b0;
    I_RX_DATA  = b;
    t = 0;
    @(negedge CLK);
    while (O_RD_UART !== 1'b1 && t < 500) begin
      @(negedge CLK);
      t++;
    end
    check("pop_seen", 32'(O_RD_UART === 1'b1), 32'd1);
    @(posedge CLK);
    #1;
    I_RX_EMPTY = 1'b1;
    bytes_sent++;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [31:0] tmp;
    tmp = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(tmp[31:24], gap);
      tmp = tmp << 8;
    end
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 2000) begin
      @(negedge CLK);
      t++;
    end
    check("done_seen", 32'(done_cnt), 32'(target));
    @(posedge CLK);
    #1;
  endtask

  logic [7:0]  rb[4];
  logic [31:0] rw;

  initial begin
    RESET       = 1'b1;
    I_RX_EMPTY  = 1'b1;
    I_RX_DATA   = 8'h00;
    I_FIFO_FULL = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_instr", O_INSTRUCTION, 32'h0);
    check("rst_count", 32'(O_INSTR_COUNT), 32'd0);
    check("rst_strobes", {27'd0, O_RD_UART, O_FLAG_I, O_LOADING, O_DONE, O_ERR}, 32'd0);
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    // Single word with back-to-back bytes
    exp_words.push_back(32'h20010005);
    exp_done.push_back(1);
    send_byte(8'h01, 0);
    check("loading_after_hdr", 32'(O_LOADING), 32'd1);
    send_word(32'h20010005, 0);
    @(negedge CLK);
    check("flag_latency", 32'(O_FLAG_I), 32'd1);
    wait_done(1);
    check("count_hold", 32'(O_INSTR_COUNT), 32'd1);

    // Illegal headers: 0x00 and 0x21
    send_byte(8'h00, 0);
    @(negedge CLK);
    check("err_pulse0", 32'(O_ERR), 32'd1);
    @(negedge CLK);
    check("err_one_cycle0", 32'(O_ERR), 32'd0);
    check("idle_after_err0", 32'(O_LOADING), 32'd0);
    @(posedge CLK);
    #1;
    send_byte(8'h21, 0);
    @(negedge CLK);
    check("err_pulse1", 32'(O_ERR), 32'd1);
    @(negedge CLK);
    check("idle_after_err1", 32'(O_LOADING), 32'd0);
    check("err_total", 32'(err_cnt), 32'd2);
    @(posedge CLK);
    #1;
    exp_words.push_back(32'hCAFEF00D);
    exp_done.push_back(1);
    send_byte(8'h01, 0);
    send_word(32'hCAFEF00D, 0);
    wait_done(2);

    // Backpressure: FIFO full while the word sits in EMIT
    exp_words.push_back(32'h12345678);
    exp_done.push_back(1);
    I_FIFO_FULL = 1'b1;
    send_byte(8'h01, 0);
    send_word(32'h12345678, 0);
    I_RX_EMPTY = 1'b0;
    I_RX_DATA  = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("bp_no_flag", 32'(O_FLAG_I), 32'd0);
      check("bp_no_pop", 32'(O_RD_UART), 32'd0);
      check("bp_stable", O_INSTRUCTION, 32'h12345678);
    end
    @(posedge CLK);
    #1;
    I_FIFO_FULL = 1'b0;
    I_RX_EMPTY  = 1'b1;
    wait_done(3);

    // RX gaps of 3 cycles between every byte
    exp_words.push_back(32'hAABBCCDD);
    exp_done.push_back(1);
    send_byte(8'h01, 3);
    send_word(32'hAABBCCDD, 3);
    wait_done(4);
    check("pops_vs_bytes", 32'(pop_cnt), 32'(bytes_sent));

    // Reset in the middle of a word
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("midrst_instr", O_INSTRUCTION, 32'h0);
    check("midrst_count", 32'(O_INSTR_COUNT), 32'd0);
    check("midrst_strobes", {27'd0, O_RD_UART, O_FLAG_I, O_LOADING, O_DONE, O_ERR}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    exp_words.push_back(32'hDEADBEEF);
    exp_done.push_back(1);
    send_byte(8'h01, 0);
    send_word(32'hDEADBEEF, 0);
    wait_done(5);

    // Full program: 32 words of random bytes
    send_byte(8'h20, 0);
    for (int w = 0; w < 32; w++) begin
      for (int k = 0; k < 4; k++) rb[k] = 8'($urandom_range(0, 255));
      rw = {rb[0], rb[1], rb[2], rb[3]};
      exp_words.push_back(rw);
      if (w == 31) exp_done.push_back(32);
      for (int k = 0; k < 4; k++) send_byte(rb[k], 0);
    end
    wait_done(6);
    check("full_count", 32'(O_INSTR_COUNT), 32'd32);

    repeat (3) @(negedge CLK);
    check("total_flags", 32'(flag_cnt), 32'd37);
    check("total_done", 32'(done_cnt), 32'd6);
    check("total_err", 32'(err_cnt), 32'd2);
    check("words_left", 32'(exp_words.size()), 32'd0);
    check("final_pops", 32'(pop_cnt), 32'(bytes_sent));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
